// File: rtl/spi_fifo_core.sv
// spi_fifo_core: register-mapped SPI master with TX and RX word FIFOs.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset_n      asynchronous active-low reset
//   cs           slot select
//   read/write   single-cycle access strobes
//   addr         register address, addr[1:0] decoded (0 status, 1 ss, 2 data, 3 ctrl)
//   wr_data      write data
//   rd_data      combinational read data, 0 when cs is low
//   spi_sclk     SPI serial clock
//   spi_miso     SPI data from slave
//   spi_mosi     SPI data to slave
//   spi_ss_n     slave selects, driven straight from the ss register
`timescale 1ns/1ps
module spi_fifo_core #(
    parameter int S      = 2,
    parameter int DW     = 8,
    parameter int FIFO_W = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic          spi_sclk,
    input  logic          spi_miso,
    output logic          spi_mosi,
    output logic [S-1:0]  spi_ss_n
);

    localparam int DEPTH = 2 ** FIFO_W;
    localparam int BCW   = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, CPHA_DELAY, P0, P1} state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [BCW-1:0]    bit_q, bit_d;
    logic [DW-1:0]     sh_q, sh_d;
    logic              mosi_q, mosi_d;

    logic [S-1:0]      ss_q;
    logic [17:0]       ctrl_q;
    logic              ovr_q;

    logic [DW-1:0]     tx_mem [DEPTH];
    logic [DW-1:0]     rx_mem [DEPTH];
    logic [FIFO_W-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [FIFO_W:0]   tx_cnt_q, rx_cnt_q;

    logic        busy, last;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_push, tx_pop, rx_push, rx_pop, rx_req;
    logic        acc_wr, acc_rd;
    logic [1:0]  sel;
    logic [15:0] dvsr;
    logic        cpol, cpha;
    logic        unused_bits;

    assign sel    = addr[1:0];
    assign acc_wr = cs && write;
    assign acc_rd = cs && read;
    assign dvsr   = ctrl_q[15:0];
    assign cpol   = ctrl_q[16];
    assign cpha   = ctrl_q[17];

    assign tx_full  = (tx_cnt_q == (FIFO_W+1)'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == (FIFO_W+1)'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);

    assign last   = (cnt_q == dvsr);
    assign tx_pop = (state_q == IDLE) && !tx_empty;
    // A push into a full FIFO still lands when a pop frees a slot in the same cycle.
    assign tx_push = acc_wr && (sel == 2'd2) && (!tx_full || tx_pop);
    assign rx_pop  = acc_rd && (sel == 2'd2) && !rx_empty;
    assign rx_req  = (state_q == P1) && last && (bit_q == BCW'(DW));
    assign rx_push = rx_req && (!rx_full || rx_pop);

    assign unused_bits = ^{addr[4:2], wr_data};

    // State register and engine datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            mosi_q  <= mosi_d;
        end
    end

    // Next-state logic: every non-IDLE state lasts dvsr+1 cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = 16'(cnt_q + 16'd1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        mosi_d  = mosi_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!tx_empty) begin
                    sh_d    = tx_mem[tx_rp_q];
                    mosi_d  = tx_mem[tx_rp_q][DW-1];
                    bit_d   = '0;
                    state_d = cpha ? CPHA_DELAY : P0;
                end
            end
            CPHA_DELAY: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = P0;
                end
            end
            P0: begin
                if (last) begin
                    // Received bits enter at the LSB; the MSB already sits on mosi_q.
                    sh_d    = {sh_q[DW-2:0], spi_miso};
                    bit_d   = BCW'(bit_q + 1'b1);
                    cnt_d   = '0;
                    state_d = P1;
                end
            end
            P1: begin
                if (last) begin
                    cnt_d = '0;
                    if (bit_q == BCW'(DW)) begin
                        state_d = IDLE;
                    end else begin
                        mosi_d  = sh_q[DW-1];
                        state_d = P0;
                    end
                end
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy     = (state_q != IDLE);
        spi_sclk = cpol ^ (((state_q == P1) && !cpha) || ((state_q == P0) && cpha));
        spi_mosi = mosi_q;
        spi_ss_n = ss_q;
    end

    // Software-visible registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ss_q   <= '1;
            ctrl_q <= 18'h0_0200;
            ovr_q  <= 1'b0;
        end else begin
            if (acc_wr && (sel == 2'd1)) ss_q <= wr_data[S-1:0];
            if (acc_wr && (sel == 2'd3) && !busy) ctrl_q <= wr_data[17:0];
            // A dropped word in the same cycle as a clear keeps the flag set.
            if (rx_req && rx_full && !rx_pop) ovr_q <= 1'b1;
            else if (acc_wr && (sel == 2'd0) && wr_data[5]) ovr_q <= 1'b0;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= FIFO_W'(tx_wp_q + 1'b1);
            if (tx_pop)  tx_rp_q <= FIFO_W'(tx_rp_q + 1'b1);
            if (tx_push && !tx_pop)      tx_cnt_q <= (FIFO_W+1)'(tx_cnt_q + 1'b1);
            else if (tx_pop && !tx_push) tx_cnt_q <= (FIFO_W+1)'(tx_cnt_q - 1'b1);
            if (rx_push) rx_wp_q <= FIFO_W'(rx_wp_q + 1'b1);
            if (rx_pop)  rx_rp_q <= FIFO_W'(rx_rp_q + 1'b1);
            if (rx_push && !rx_pop)      rx_cnt_q <= (FIFO_W+1)'(rx_cnt_q + 1'b1);
            else if (rx_pop && !rx_push) rx_cnt_q <= (FIFO_W+1)'(rx_cnt_q - 1'b1);
        end
    end

    // FIFO storage carries data only, so it needs no reset
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= wr_data[DW-1:0];
        if (rx_push) rx_mem[rx_wp_q] <= sh_q;
    end

    // Read mux
    always_comb begin
        rd_data = '0;
        if (cs) begin
            case (sel)
                2'd0: rd_data[5:0] = {ovr_q, busy, tx_full, tx_empty, rx_full, rx_empty};
                2'd1: rd_data[S-1:0] = ss_q;
                2'd2: if (!rx_empty) rd_data[DW-1:0] = rx_mem[rx_rp_q];
                2'd3: rd_data[17:0] = ctrl_q;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fifo_core.sv
`timescale 1ns/1ps
module tb_spi_fifo_core;

    localparam int S      = 2;
    localparam int DW     = 8;
    localparam int FIFO_W = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        spi_sclk;
    logic        spi_mosi;
    logic [S-1:0] spi_ss_n;
    logic        loopback = 1'b0;
    logic        miso_force = 1'b0;
    logic        spi_miso;

    assign spi_miso = loopback ? spi_mosi : miso_force;

    spi_fifo_core #(.S(S), .DW(DW), .FIFO_W(FIFO_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .spi_sclk (spi_sclk),
        .spi_miso (spi_miso),
        .spi_mosi (spi_mosi),
        .spi_ss_n (spi_ss_n)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;

    typedef struct {
        int cycles;
        int pulses;
        int period;
    } xf_exp_t;

    rd_exp_t rd_q[$];
    xf_exp_t xf_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Register-read monitor
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (cs && read) begin
                if (rd_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_read: got 0x%0h expected no read", rd_data);
                end else begin
                    e = rd_q.pop_front();
                    chk(e.name, rd_data, e.exp);
                end
            end
        end
    end

    // Transfer monitor: busy length, leading sclk edges, edge spacing
    initial begin
        bit   in_xfer = 1'b0;
        logic prev_sclk = 1'b0;
        logic idle_lvl = 1'b0;
        int   cyc = 0, pulses = 0, t1 = 0, t2 = 0;
        xf_exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_xfer = 1'b0;
            end else if (dut.busy) begin
                if (!in_xfer) begin
                    in_xfer  = 1'b1;
                    cyc      = 0;
                    pulses   = 0;
                    t1       = 0;
                    t2       = 0;
                    idle_lvl = prev_sclk;
                end
                cyc++;
                if (spi_sclk != idle_lvl && prev_sclk == idle_lvl) begin
                    pulses++;
                    if (pulses == 1) t1 = cyc;
                    if (pulses == 2) t2 = cyc;
                end
            end else if (in_xfer) begin
                in_xfer = 1'b0;
                if (xf_q.size() != 0) begin
                    e = xf_q.pop_front();
                    chk("xfer_cycles", cyc, e.cycles);
                    chk("xfer_pulses", pulses, e.pulses);
                    chk("xfer_period", t2 - t1, e.period);
                end
            end
            prev_sclk = spi_sclk;
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cs = 1'b1; write = 1'b1; addr = {3'b000, a}; wr_data = d;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        rd_q.push_back('{name: nm, exp: e});
        @(posedge clk); #1;
        cs = 1'b1; read = 1'b1; addr = {3'b000, a};
        @(posedge clk); #1;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        rd(2'd0, 32'h05,  "rst_status");
        rd(2'd1, 32'h03,  "rst_ss");
        rd(2'd3, 32'h200, "rst_ctrl");
        rd(2'd2, 32'h00,  "rst_data_empty");
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_ss_n", spi_ss_n, 2'b11);
        @(posedge clk); #1;
        read = 1'b1; addr = 5'd3;
        #2 chk("cs_low_rd", rd_data, 0);
        read = 1'b0;

        // mode 0, dvsr=1, loopback
        wr(2'd1, 32'h0);
        chk("ss_write", spi_ss_n, 2'b00);
        wr(2'd3, 32'h0_0001);
        loopback = 1'b1;
        xf_q.push_back('{cycles: 32, pulses: 8, period: 4});
        wr(2'd2, 32'hA5);
        idle(50);
        rd(2'd2, 32'hA5, "m0_rx");
        rd(2'd0, 32'h05, "m0_status");

        // mode 3, dvsr=0, miso held high
        loopback   = 1'b0;
        miso_force = 1'b1;
        wr(2'd3, 32'h3_0000);
        chk("m3_sclk_idle", spi_sclk, 1);
        xf_q.push_back('{cycles: 17, pulses: 8, period: 2});
        wr(2'd2, 32'h3C);
        idle(30);
        rd(2'd2, 32'hFF,    "m3_rx");
        rd(2'd3, 32'h3_0000, "m3_ctrl");

        // engine stalled: one word in the shifter, four queued, sixth dropped
        wr(2'd3, 32'h0_FFFF);
        for (int i = 0; i < 6; i++) wr(2'd2, 32'h10 + i);
        rd(2'd0, 32'h19, "txfull_status");
        wr(2'd3, 32'h0_0001);
        rd(2'd3, 32'hFFFF, "ctrl_busy_ignored");
        pulse_reset();
        rd(2'd0, 32'h05, "post_reset_status");

        // RX overrun with five looped-back words
        wr(2'd3, 32'h0);
        loopback = 1'b1;
        wr(2'd2, 32'h81);
        wr(2'd2, 32'h42);
        wr(2'd2, 32'h24);
        wr(2'd2, 32'h18);
        wr(2'd2, 32'hE7);
        idle(120);
        rd(2'd0, 32'h26, "ovr_status");
        wr(2'd0, 32'h20);
        rd(2'd0, 32'h06, "ovr_cleared");
        rd(2'd2, 32'h81, "ovr_rx0");
        rd(2'd2, 32'h42, "ovr_rx1");
        rd(2'd2, 32'h24, "ovr_rx2");
        rd(2'd2, 32'h18, "ovr_rx3");
        rd(2'd0, 32'h05, "drained_status");
        rd(2'd2, 32'h00, "empty_read");

        // reset asserted during bit 3
        wr(2'd1, 32'h0);
        wr(2'd3, 32'h0_0003);
        loopback   = 1'b0;
        miso_force = 1'b0;
        wr(2'd2, 32'hC3);
        repeat (30) @(posedge clk);
        #1;
        chk("pre_reset_busy", dut.busy, 1);
        chk("pre_reset_sclk", spi_sclk, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_sclk", spi_sclk, 0);
        chk("async_rst_ss_n", spi_ss_n, 2'b11);
        chk("async_rst_mosi", spi_mosi, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rd(2'd0, 32'h05,  "abort_status");
        rd(2'd3, 32'h200, "abort_ctrl");
        rd(2'd1, 32'h03,  "abort_ss");
        rd(2'd2, 32'h00,  "abort_rx_empty");

        idle(3);
        chk("sb_rd_drained", rd_q.size(), 0);
        chk("sb_xf_drained", xf_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
